ascon_perm_digit_serial: RTL and testbench

//  Digit-serial Ascon permutation core: the parametrised successor of the bit-serial one-round permutation.

---
 rtl/ascon_perm_digit_serial.sv | 206 ++++++++++++++++++++
 tb/tb_ascon_perm_digit_serial.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_perm_digit_serial.sv
// Digit-serial Ascon permutation core.
// Holds the 320-bit Ascon state as five 64-bit lanes x0..x4. Lane digits are
// streamed in and out over valid/ready handshakes, DW bits per lane per beat,
// most significant digit first. The core generates its own round constants and
// runs a per-job round count (0..12; larger requests are treated as 12).
// Loads may overwrite or XOR-absorb into the retained state, beat by beat.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   load beat valid
//   in_ready   core accepts a load beat (IDLE/LOAD)
//   in_data    {x0,x1,x2,x3,x4} digits, each lane MSB digit first
//   in_xor     per beat: 1 = state digit ^= in_data, 0 = overwrite
//   in_rounds  rounds for this job, sampled on the first load beat only
//   out_valid  unload beat valid (UNLOAD)
//   out_ready  unload beat accepted
//   out_data   {x0..x4} digits, MSB digit first
//   busy       high outside IDLE
module ascon_perm_digit_serial #(
    parameter int DW = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5*DW-1:0] in_data,
    input  logic            in_xor,
    input  logic [3:0]      in_rounds,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5*DW-1:0] out_data,
    output logic            busy
);

    localparam int NBEAT = 64 / DW;
    localparam int CW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBEAT - 1);

    if (!(DW == 1 || DW == 2 || DW == 4 || DW == 8 ||
          DW == 16 || DW == 32 || DW == 64)) begin : g_bad_dw
        $fatal(1, "ascon_perm_digit_serial: illegal DW %0d", DW);
    end

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SBOX,
        LIN,
        UNLOAD
    } state_t;

    state_t                state, state_nxt;
    logic [0:4][63:0]      x, x_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [3:0]            r, r_nxt;
    logic [3:0]            nr, nr_nxt;

    logic [5:0]            lsb;       // bit position of the current digit's LSB
    logic [7:0]            rc;
    logic [63:0]           x2c;       // x2 with the round constant applied
    logic [0:4][DW-1:0]    dig;       // current digit of each lane
    logic [0:4][DW-1:0]    ind;       // incoming digits, x0 first
    logic [0:4][DW-1:0]    sin;
    logic [0:4][DW-1:0]    sout;
    logic [3:0]            nr_clamp;
    logic [3:0]            nr_use;

    function automatic logic [0:4][DW-1:0] sbox(input logic [0:4][DW-1:0] a);
        logic [DW-1:0] s0, s1, s2, s3, s4;
        logic [DW-1:0] t0, t1, t2, t3, t4;
        s0 = a[0] ^ a[4];
        s1 = a[1];
        s2 = a[2] ^ a[1];
        s3 = a[3];
        s4 = a[4] ^ a[3];
        t0 = ~s0 & s1;
        t1 = ~s1 & s2;
        t2 = ~s2 & s3;
        t3 = ~s3 & s4;
        t4 = ~s4 & s0;
        s0 = s0 ^ t1;
        s1 = s1 ^ t2;
        s2 = s2 ^ t3;
        s3 = s3 ^ t4;
        s4 = s4 ^ t0;
        s1 = s1 ^ s0;
        s0 = s0 ^ s4;
        s3 = s3 ^ s2;
        s2 = ~s2;
        return {s0, s1, s2, s3, s4};
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] v, input int unsigned n);
        return (v >> n) | (v << (64 - n));
    endfunction

    assign ind      = in_data;
    assign nr_clamp = (in_rounds > 4'd12) ? 4'd12 : in_rounds;
    // Digit k lives at bits 63-k*DW .. 64-(k+1)*DW.
    assign lsb      = 6'(DW) * 6'(LAST - cnt);
    // Constant only touches x2[7:0]; folding it into the S-box input means it
    // lands in the same pass as those columns.
    assign rc       = 8'hF0 - ({4'd0, r} * 8'h0F);
    assign x2c      = x[2] ^ {56'd0, rc};

    always_comb begin
        for (int unsigned i = 0; i < 5; i++) begin
            dig[i] = x[i][lsb +: DW];
        end
        sin    = dig;
        sin[2] = x2c[lsb +: DW];
        sout   = sbox(sin);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            x     <= '0;
            cnt   <= '0;
            r     <= '0;
            nr    <= '0;
        end else begin
            state <= state_nxt;
            x     <= x_nxt;
            cnt   <= cnt_nxt;
            r     <= r_nxt;
            nr    <= nr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        cnt_nxt   = cnt;
        r_nxt     = r;
        nr_nxt    = nr;
        // The first beat is taken in IDLE, so the fresh round count must be
        // used directly there when NBEAT==1 makes it the last beat too.
        nr_use    = (state == IDLE) ? nr_clamp : nr;

        case (state)
            IDLE, LOAD: begin
                if (in_valid) begin
                    if (state == IDLE) begin
                        nr_nxt = nr_clamp;
                    end
                    for (int unsigned i = 0; i < 5; i++) begin
                        x_nxt[i][lsb +: DW] = in_xor ? (dig[i] ^ ind[i]) : ind[i];
                    end
                    if (cnt == LAST) begin
                        cnt_nxt = '0;
                        if (nr_use == 4'd0) begin
                            state_nxt = UNLOAD;
                        end else begin
                            state_nxt = SBOX;
                            r_nxt     = 4'd12 - nr_use;
                        end
                    end else begin
                        cnt_nxt   = cnt + CW'(1);
                        state_nxt = LOAD;
                    end
                end
            end
            SBOX: begin
                for (int unsigned i = 0; i < 5; i++) begin
                    x_nxt[i][lsb +: DW] = sout[i];
                end
                if (cnt == LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = LIN;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            LIN: begin
                x_nxt[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
                x_nxt[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
                x_nxt[2] = x[2] ^ ror(x[2], 1)  ^ ror(x[2], 6);
                x_nxt[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
                x_nxt[4] = x[4] ^ ror(x[4], 7)  ^ ror(x[4], 41);
                r_nxt    = r + 4'd1;
                state_nxt = (r == 4'd11) ? UNLOAD : SBOX;
            end
            UNLOAD: begin
                if (out_ready) begin
                    if (cnt == LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign in_ready  = (state == IDLE) || (state == LOAD);
    assign out_valid = (state == UNLOAD);
    assign busy      = (state != IDLE);
    assign out_data  = out_valid ? dig : '0;

endmodule

// File: tb/tb_ascon_perm_digit_serial.sv
// Testbench for ascon_perm_digit_serial.
// Two instances: DW=8 (randomized jobs, bubbles, back-pressure, XOR absorb,
// round clamp, mid-job reset) and DW=1 (the reference p12 job and its clamped
// twin). Expected unload beats come from a table-driven Ascon model and are
// queued at issue time; monitors pop and compare as the cores unload.
module tb_ascon_perm_digit_serial;

    localparam int DWA = 8;
    localparam int NBA = 8;
    localparam int DWB = 1;
    localparam int NBB = 64;

    localparam logic [4:0] SBOX_TAB [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic              in_valid_a = 1'b0, in_ready_a, in_xor_a = 1'b0;
    logic [5*DWA-1:0]  in_data_a = '0;
    logic [3:0]        in_rounds_a = '0;
    logic              out_valid_a, out_ready_a = 1'b0, busy_a;
    logic [5*DWA-1:0]  out_data_a;

    logic              in_valid_b = 1'b0, in_ready_b, in_xor_b = 1'b0;
    logic [5*DWB-1:0]  in_data_b = '0;
    logic [3:0]        in_rounds_b = '0;
    logic              out_valid_b, out_ready_b = 1'b1, busy_b;
    logic [5*DWB-1:0]  out_data_b;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;

    logic [5*DWA-1:0] qa[$];
    logic [5*DWB-1:0] qb[$];
    logic [0:4][63:0] ms_a = '0;
    logic [0:4][63:0] ms_b = '0;

    logic             stalled_a = 1'b0;
    logic [5*DWA-1:0] held_a = '0;

    ascon_perm_digit_serial #(.DW(DWA)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .in_data   (in_data_a),
        .in_xor    (in_xor_a),
        .in_rounds (in_rounds_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready_a),
        .out_data  (out_data_a),
        .busy      (busy_a)
    );

    ascon_perm_digit_serial #(.DW(DWB)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .in_data   (in_data_b),
        .in_xor    (in_xor_b),
        .in_rounds (in_rounds_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .out_data  (out_data_b),
        .busy      (busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // Ascon permutation over the last nr rounds, S-box by table lookup.
    function automatic logic [0:4][63:0] perm(input logic [0:4][63:0] s, input int nr);
        logic [0:4][63:0] t;
        logic [4:0] v, o;
        t = s;
        for (int r = 12 - nr; r < 12; r++) begin
            t[2] = t[2] ^ 64'(240 - 15 * r);
            for (int c = 0; c < 64; c++) begin
                v = {t[0][c], t[1][c], t[2][c], t[3][c], t[4][c]};
                o = SBOX_TAB[v];
                t[0][c] = o[4];
                t[1][c] = o[3];
                t[2][c] = o[2];
                t[3][c] = o[1];
                t[4][c] = o[0];
            end
            t[0] = t[0] ^ ror(t[0], 19) ^ ror(t[0], 28);
            t[1] = t[1] ^ ror(t[1], 61) ^ ror(t[1], 39);
            t[2] = t[2] ^ ror(t[2], 1)  ^ ror(t[2], 6);
            t[3] = t[3] ^ ror(t[3], 10) ^ ror(t[3], 17);
            t[4] = t[4] ^ ror(t[4], 7)  ^ ror(t[4], 41);
        end
        return t;
    endfunction

    function automatic logic [0:4][63:0] load_beat(input logic [0:4][63:0] s,
                                                   input logic [0:4][63:0] l,
                                                   input logic xr, input int k, input int dw);
        logic [63:0] m;
        logic [0:4][63:0] t;
        m = ((64'd1 << dw) - 64'd1) << (64 - (k + 1) * dw);
        t = s;
        for (int i = 0; i < 5; i++) begin
            t[i] = xr ? (s[i] ^ (l[i] & m)) : ((s[i] & ~m) | (l[i] & m));
        end
        return t;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic job_a(input logic [0:4][63:0] lanes, input logic [NBA-1:0] xmask,
                         input int nr, input int bubble_at, input int rst_after);
        int nreff, w, t_last;
        logic [5*DWA-1:0] d;
        logic [0:4][63:0] res;
        nreff = (nr > 12) ? 12 : nr;
        t_last = 0;
        for (int k = 0; k < NBA; k++) begin
            if (k == bubble_at) begin
                in_valid_a = 1'b0;
                @(posedge clk); #1;
            end
            for (int i = 0; i < 5; i++) d[(4 - i) * DWA +: DWA] = 8'(lanes[i] >> (56 - 8 * k));
            in_data_a   = d;
            in_xor_a    = xmask[k];
            in_rounds_a = (k == 0) ? 4'(nr) : 4'($urandom);
            in_valid_a  = 1'b1;
            w = 0;
            while (!in_ready_a && w < 4000) begin @(posedge clk); #1; w++; end
            if (!in_ready_a) begin
                checks++; errors++;
                $display("FAIL load_wait_a: in_ready stuck low, beat %0d", k);
                in_valid_a = 1'b0;
                return;
            end
            t_last = cyc_cnt;
            @(posedge clk); #1;
            ms_a = load_beat(ms_a, lanes, xmask[k], k, DWA);
        end
        in_valid_a = 1'b0;
        if (rst_after >= 0) begin
            repeat (rst_after) @(posedge clk);
            #1 rst = 1'b1;
            #2;
            check("rst_busy_a", 320'(busy_a), 320'(0));
            check("rst_out_valid_a", 320'(out_valid_a), 320'(0));
            check("rst_in_ready_a", 320'(in_ready_a), 320'(1));
            rst = 1'b0;
            ms_a = '0;
            return;
        end
        res  = perm(ms_a, nreff);
        ms_a = res;
        for (int k = 0; k < NBA; k++) begin
            for (int i = 0; i < 5; i++) d[(4 - i) * DWA +: DWA] = 8'(res[i] >> (56 - 8 * k));
            qa.push_back(d);
        end
        w = 0;
        while (!out_valid_a && w < 2000) begin @(posedge clk); #1; w++; end
        check("latency_a", 320'(cyc_cnt - t_last), 320'(nreff * (NBA + 1) + 1));
    endtask

    task automatic job_b(input logic [0:4][63:0] lanes, input int nr);
        int nreff, w, t_first;
        logic [4:0] d;
        logic [0:4][63:0] res;
        nreff = (nr > 12) ? 12 : nr;
        t_first = 0;
        for (int k = 0; k < NBB; k++) begin
            for (int i = 0; i < 5; i++) d[4 - i] = lanes[i][63 - k];
            in_data_b   = d;
            in_xor_b    = 1'b0;
            in_rounds_b = (k == 0) ? 4'(nr) : 4'($urandom);
            in_valid_b  = 1'b1;
            w = 0;
            while (!in_ready_b && w < 4000) begin @(posedge clk); #1; w++; end
            if (!in_ready_b) begin
                checks++; errors++;
                $display("FAIL load_wait_b: in_ready stuck low, beat %0d", k);
                in_valid_b = 1'b0;
                return;
            end
            if (k == 0) t_first = cyc_cnt;
            @(posedge clk); #1;
            ms_b = load_beat(ms_b, lanes, 1'b0, k, DWB);
        end
        in_valid_b = 1'b0;
        res  = perm(ms_b, nreff);
        ms_b = res;
        for (int k = 0; k < NBB; k++) begin
            for (int i = 0; i < 5; i++) d[4 - i] = res[i][63 - k];
            qb.push_back(d);
        end
        w = 0;
        while (!out_valid_b && w < 4000) begin @(posedge clk); #1; w++; end
        check("latency_b", 320'(cyc_cnt - t_first), 320'(NBB + nreff * (NBB + 1)));
    endtask

    // Random back-pressure on the DW=8 unload side.
    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready_a = ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            stalled_a = 1'b0;
        end else if (out_valid_a) begin
            if (stalled_a) check("hold_a", 320'(out_data_a), 320'(held_a));
            if (out_ready_a) begin
                if (qa.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_a: got %0h expected no beat", out_data_a);
                end else begin
                    check("unload_a", 320'(out_data_a), 320'(qa.pop_front()));
                end
                stalled_a = 1'b0;
            end else begin
                stalled_a = 1'b1;
                held_a    = out_data_a;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid_b && out_ready_b) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_b: got %0h expected no beat", out_data_b);
            end else begin
                check("unload_b", 320'(out_data_b), 320'(qb.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [0:4][63:0] l;
        int w;

        #12;
        check("reset_in_ready_a", 320'(in_ready_a), 320'(1));
        check("reset_out_valid_a", 320'(out_valid_a), 320'(0));
        check("reset_out_data_a", 320'(out_data_a), 320'(0));
        check("reset_busy_a", 320'(busy_a), 320'(0));
        check("reset_in_ready_b", 320'(in_ready_b), 320'(1));
        check("reset_busy_b", 320'(busy_b), 320'(0));
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // DW=1: p12 on the reference IV, then the same request with rounds=15.
        l = {64'h80400c0600000000, 64'h0, 64'h0, 64'h0, 64'h0};
        job_b(l, 12);
        job_b(l, 15);

        // DW=8: p6 with a bubble, then an XOR-absorb p6 on the retained state.
        for (int i = 0; i < 5; i++) l[i] = rnd64();
        job_a(l, '0, 6, 4, -1);
        l = {64'h0100001000010000, 64'h0, 64'h0, 64'h0, 64'h0};
        job_a(l, '1, 6, -1, -1);
        // nr=0 echoes the loaded value.
        for (int i = 0; i < 5; i++) l[i] = rnd64();
        job_a(l, '0, 0, -1, -1);
        // rounds above 12 behave as 12, with mixed per-beat absorb.
        for (int i = 0; i < 5; i++) l[i] = rnd64();
        job_a(l, 8'($urandom), 15, 2, -1);
        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < 5; i++) l[i] = rnd64();
            job_a(l, 8'($urandom), $urandom_range(0, 15), $urandom_range(0, NBA), -1);
        end
        // Reset during the S-box pass of round 5, then read back the cleared state.
        for (int i = 0; i < 5; i++) l[i] = rnd64();
        job_a(l, '0, 12, -1, 4 * (NBA + 1) + 3);
        job_a('0, '1, 0, -1, -1);

        w = 0;
        while ((qa.size() != 0 || qb.size() != 0) && w < 5000) begin
            @(posedge clk); #1; w++;
        end
        if (qa.size() != 0 || qb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: got %0d/%0d beats pending expected 0/0", qa.size(), qb.size());
        end
        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
